// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit FIFO slice:
// drain FSM state encoding, byte width and default FIFO depth.
package uart_pkg;

    localparam int UART_BYTE_W    = 8;
    localparam int DEF_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_FREE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: registered write, combinational read.
// Ports: clk, we/waddr/wdata (write side), raddr/rdata (read side).
module sync_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1<<ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter via transmit/tx_byte/tx_free.
// Ports: clk, rst (async, active-low); producer side wr_en/wr_data with
// full/empty/level/overflow/clr_overflow; uart side transmit/tx_byte/tx_free.
// Optional UART_TXFIFO_STATS_EN adds tx_count and drop_count outputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH_LOG2:0]    level,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   transmit,
    output logic [UART_BYTE_W-1:0] tx_byte,
    input  logic                   tx_free
`ifdef UART_TXFIFO_STATS_EN
    ,
    output logic [15:0]            tx_count,
    output logic [15:0]            drop_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);

    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [UART_BYTE_W-1:0] rd_data;
    logic [TW-1:0]          wait_cnt;
    tx_state_t              state;
    logic                   do_wr;
    logic                   do_rd;
    logic                   drop;

    assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (level == '0) && (state == IDLE);
    assign do_wr = wr_en && !full;
    assign drop  = wr_en && full;
    // Pop only when handing a byte to an idle uart.
    assign do_rd = (state == IDLE) && (level != '0) && tx_free;

    sync_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (UART_BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
            // A new overflow beats a simultaneous clear.
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            transmit <= 1'b0;
            tx_byte  <= '0;
            wait_cnt <= '0;
        end else begin
            transmit <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (do_rd) begin
                        tx_byte  <= rd_data;
                        transmit <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // If the uart never drops tx_free, assume it took the byte.
                    if (!tx_free) begin
                        state <= WAIT_FREE;
                    end else if (wait_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        state <= WAIT_FREE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_FREE: begin
                    if (tx_free) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_TXFIFO_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (do_rd) tx_count   <= tx_count + 1'b1;
            if (drop)  drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple uart model that
// records every transmitted byte and holds tx_free low for a while.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       tx_free = 1'b1;
`ifdef UART_TXFIFO_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int failures = 0;

    uart_tx_fifo #(
        .DEPTH_LOG2  (4),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .transmit     (transmit),
        .tx_byte      (tx_byte),
        .tx_free      (tx_free)
`ifdef UART_TXFIFO_STATS_EN
        ,
        .tx_count     (tx_count),
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    // uart model: hold = cycles tx_free stays low after a pulse
    // (0 = never drops), stall forces tx_free low.
    int         hold  = 40;
    bit         stall = 1'b0;
    int         busy  = 0;
    int         cyc   = 0;
    logic [7:0] rx_q [$];
    int         ts_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            busy = 0;
        end else if (transmit) begin
            rx_q.push_back(tx_byte);
            ts_q.push_back(cyc);
            busy = hold;
        end else if (busy > 0) begin
            busy--;
        end
        tx_free = !stall && (busy == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        int n;
        n = 0;
        while (!empty && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        int errs;
        int idx;
        int g;

        // reset state
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_empty", {31'd0, empty}, 1);
        check("rst_level", {27'd0, level}, 0);
        check("rst_full", {31'd0, full}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_xmit", {31'd0, transmit}, 0);
        check("rst_byte", {24'd0, tx_byte}, 0);

        // idle: no pulses
        repeat (100) tick();
        check("idle_pulses", rx_q.size(), 0);
        check("idle_empty", {31'd0, empty}, 1);

        // single byte latency
        hold = 40;
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("a5_lvl1", {27'd0, level}, 1);
        check("a5_nox1", {31'd0, transmit}, 0);
        check("a5_empty1", {31'd0, empty}, 0);
        tick();
        check("a5_xmit", {31'd0, transmit}, 1);
        check("a5_byte", {24'd0, tx_byte}, 32'hA5);
        check("a5_lvl0", {27'd0, level}, 0);
        check("a5_empty2", {31'd0, empty}, 0);
        tick();
        check("a5_onepulse", {31'd0, transmit}, 0);
        check("a5_hold", {24'd0, tx_byte}, 32'hA5);
        wait_empty(100, "a5_done");
        check("a5_rxn", rx_q.size(), 1);
        check("a5_rx", {24'd0, rx_q[0]}, 32'hA5);

        // burst 16 with uart stalled, then drain in order
        rx_q.delete();
        ts_q.delete();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("b16_level", {27'd0, level}, 16);
        check("b16_full", {31'd0, full}, 1);
        check("b16_ovf", {31'd0, overflow}, 0);
        hold = 3;
        stall = 1'b0;
        wait_empty(400, "b16_done");
        check("b16_rxn", rx_q.size(), 16);
        errs = 0;
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] !== 8'(i)) errs++;
        check("b16_order", errs, 0);
        check("b16_ovf2", {31'd0, overflow}, 0);
`ifdef UART_TXFIFO_STATS_EN
        check("b16_txcnt", {16'd0, tx_count}, 17);
`endif

        // overflow: 18 writes into a stalled FIFO
        rx_q.delete();
        ts_q.delete();
        stall = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h20 + i);
            tick();
        end
        wr_en = 1'b0;
        check("ov_level", {27'd0, level}, 16);
        check("ov_flag", {31'd0, overflow}, 1);
`ifdef UART_TXFIFO_STATS_EN
        check("ov_drops", {16'd0, drop_count}, 2);
`endif
        wr_en = 1'b1;
        wr_data = 8'hEE;
        clr_overflow = 1'b1;
        tick();
        wr_en = 1'b0;
        check("ov_setwins", {31'd0, overflow}, 1);
        check("ov_level2", {27'd0, level}, 16);
`ifdef UART_TXFIFO_STATS_EN
        check("ov_drops3", {16'd0, drop_count}, 3);
`endif
        tick();
        clr_overflow = 1'b0;
        check("ov_clr", {31'd0, overflow}, 0);
        stall = 1'b0;
        wait_empty(400, "ov_done");
        check("ov_rxn", rx_q.size(), 16);
        check("ov_first", {24'd0, rx_q[0]}, 32'h20);
        check("ov_last", {24'd0, rx_q[15]}, 32'h2F);

        // uart never drops tx_free: ack timeout path
        rx_q.delete();
        ts_q.delete();
        hold = 0;
        tick();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        tick();
        wr_data = 8'hC3;
        tick();
        wr_en = 1'b0;
        wait_empty(100, "to_done");
        check("to_rxn", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("to_b0", {24'd0, rx_q[0]}, 32'h5A);
            check("to_b1", {24'd0, rx_q[1]}, 32'hC3);
            check("to_gap", ts_q[1] - ts_q[0], 7);
        end

        // sustained writes while draining, 256 bytes
        rx_q.delete();
        ts_q.delete();
        hold = 2;
        idx = 0;
        g = 0;
        while (idx < 256 && g < 5000) begin
            wr_en = !full;
            wr_data = 8'(idx);
            tick();
            if (wr_en) idx++;
            g++;
        end
        wr_en = 1'b0;
        check("ss_written", idx, 256);
        wait_empty(500, "ss_done");
        check("ss_rxn", rx_q.size(), 256);
        errs = 0;
        for (int i = 0; i < rx_q.size(); i++)
            if (rx_q[i] !== 8'(i)) errs++;
        check("ss_order", errs, 0);
        check("ss_ovf", {31'd0, overflow}, 0);
`ifdef UART_TXFIFO_STATS_EN
        check("ss_txcnt", {16'd0, tx_count}, 291);
`endif

        // asynchronous reset mid-operation
        hold = 40;
        stall = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h80 + i);
            tick();
        end
        wr_en = 1'b0;
        check("mr_ovf", {31'd0, overflow}, 1);
        stall = 1'b0;
        g = 0;
        while (!transmit && g < 50) begin
            tick();
            g++;
        end
        check("mr_xmit", {31'd0, transmit}, 1);
        #2 rst = 1'b0;
        #1;
        check("mr_xmit0", {31'd0, transmit}, 0);
        check("mr_level", {27'd0, level}, 0);
        check("mr_empty", {31'd0, empty}, 1);
        check("mr_full", {31'd0, full}, 0);
        check("mr_ovf0", {31'd0, overflow}, 0);
        check("mr_byte", {24'd0, tx_byte}, 0);
`ifdef UART_TXFIFO_STATS_EN
        check("mr_txcnt", {16'd0, tx_count}, 0);
        check("mr_drops", {16'd0, drop_count}, 0);
`endif
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("mr_after", {31'd0, empty}, 1);
        check("mr_quiet", {31'd0, transmit}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
